// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: op codes, flag bit positions,
// and sequencer state encodings.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_RSH = 3'd1;
    localparam logic [2:0] OP_LSH = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    localparam int FLAG_C  = 3;
    localparam int FLAG_AL = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_Z  = 0;

    // ST_ILL is the single wait cycle before an illegal instruction reports back.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S4   = 3'd1,
        ST_S5   = 3'd2,
        ST_S6   = 3'd3,
        ST_ILL  = 3'd4
    } state_t;
endpackage

// File: rtl/alu.sv
// Combinational ALU. Shifts and ADD use c_in; a_larger/equal only report on CMP,
// and CMP yields A^B so zero also flags equality.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             c_out,
    output logic             a_larger,
    output logic             equal,
    output logic             zero
);
    always_comb begin
        c        = '0;
        c_out    = 1'b0;
        a_larger = 1'b0;
        equal    = 1'b0;
        case (op)
            OP_ADD: {c_out, c} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
            OP_RSH: begin c = {c_in, a[WIDTH-1:1]}; c_out = a[0]; end
            OP_LSH: begin c = {a[WIDTH-2:0], c_in}; c_out = a[WIDTH-1]; end
            // DEC reports a borrow when wrapping from zero.
            OP_DEC: begin c = a - {{(WIDTH-1){1'b0}}, 1'b1}; c_out = (a == '0); end
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            default: begin
                c        = a ^ b;
                a_larger = (a > b);
                equal    = (a == b);
            end
        endcase
        zero = (c == '0);
    end
endmodule

// File: rtl/alu_instr_sequencer.sv
// Steps one ALU instruction through TMP<-Rb, ACC<-ALU(Ra,TMP), Rb<-ACC and latches flags.
// Owns the register file, TMP, ACC and flag register.
module alu_instr_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [7:0]       instr,
    input  logic             clf,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       flags,
    output logic             done,
    output logic             illegal
);
    state_t                      state;
    logic [6:0]                  instr_q;
    logic [NREG-1:0][WIDTH-1:0]  regs;
    logic [WIDTH-1:0]            tmp, acc, alu_c;
    logic                        alu_cout, alu_al, alu_eq, alu_z;
    logic [2:0]                  op;
    logic [AW-1:0]               ra, rb;

    assign op      = instr_q[6:4];
    assign ra      = instr_q[3:2];
    assign rb      = instr_q[1:0];
    assign ready   = (state == ST_IDLE);
    assign rd_data = regs[rd_addr];

    alu #(.WIDTH(WIDTH)) u_alu (
        .a(regs[ra]), .b(tmp), .c_in(flags[FLAG_C]), .op(op),
        .c(alu_c), .c_out(alu_cout), .a_larger(alu_al), .equal(alu_eq), .zero(alu_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            instr_q <= '0;
            regs    <= '0;
            tmp     <= '0;
            acc     <= '0;
            flags   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A same-cycle preload lands before S4 reads the register file.
                    if (wr_en) regs[wr_addr] <= wr_data;
                    if (start) begin
                        instr_q <= instr[6:0];
                        state   <= instr[7] ? ST_S4 : ST_ILL;
                    end else if (clf) begin
                        flags <= '0;
                    end
                end
                ST_S4: begin
                    tmp   <= regs[rb];
                    state <= ST_S5;
                end
                ST_S5: begin
                    acc   <= alu_c;
                    flags <= {alu_cout, alu_al, alu_eq, alu_z};
                    state <= ST_S6;
                end
                ST_S6: begin
                    if (op != OP_CMP) regs[rb] <= acc;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_ILL: begin
                    done    <= 1'b1;
                    illegal <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
